// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures the period and high phase of a divided clock
// in ref_clk cycles and flags ratio, duty and stuck-clock errors.
module clk_ratio_monitor #(
   parameter int DIV_RATIO_WIDTH = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                       ref_clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       clk_in,
   input  logic [DIV_RATIO_WIDTH-1:0] expected_ratio,
   output logic [CNT_WIDTH-1:0]       meas_period,
   output logic [CNT_WIDTH-1:0]       meas_high,
   output logic                       meas_valid,
   output logic                       ratio_err,
   output logic                       stuck_err,
   output logic [7:0]                 err_count
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT =
      CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

   typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

   state_t               state;
   logic                 s1, s2, s3;
   logic                 rise, fall;
   logic                 active;
   logic [CNT_WIDTH-1:0] hi_cnt, lo_cnt;
   logic [CNT_WIDTH-1:0] period_sum;
   logic [CNT_WIDTH-1:0] phase_diff;
   logic [CNT_WIDTH-1:0] ratio_ext;
   logic                 ratio_bad;
   logic                 done;
   logic                 stuck_hit;
   logic                 err_hit;

   assign rise   = s2 & ~s3;
   assign fall   = ~s2 & s3;
   assign active = enable && (expected_ratio > DIV_RATIO_WIDTH'(1));

   // measurement arithmetic and error qualification for this cycle
   always_comb begin
      ratio_ext  = CNT_WIDTH'(expected_ratio);
      period_sum = hi_cnt + lo_cnt;
      phase_diff = (hi_cnt >= lo_cnt) ? (hi_cnt - lo_cnt)
                                      : (lo_cnt - hi_cnt);
      ratio_bad  = (period_sum != ratio_ext) || (phase_diff > ONE);
      done       = active && (state == LOW) && rise;
      stuck_hit  = 1'b0;
      if (active) begin
         unique case (state)
            SYNC:    stuck_hit = !rise && (hi_cnt == TIMEOUT);
            HIGH:    stuck_hit = !fall && (hi_cnt == TIMEOUT);
            LOW:     stuck_hit = !rise && (lo_cnt == TIMEOUT);
            default: stuck_hit = 1'b0;
         endcase
      end
      err_hit = (done && ratio_bad) || stuck_hit;
   end

   // two-flop synchronizer plus a third flop for edge detection
   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // phase-tracking FSM with registered measurement and pulse outputs
   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         hi_cnt      <= '0;
         lo_cnt      <= '0;
         meas_period <= '0;
         meas_high   <= '0;
         meas_valid  <= 1'b0;
         ratio_err   <= 1'b0;
         stuck_err   <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         ratio_err  <= 1'b0;
         stuck_err  <= 1'b0;
         if (!active) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  hi_cnt <= ONE;
                  state  <= SYNC;
               end
               SYNC: begin
                  if (rise) begin
                     hi_cnt <= ONE;
                     state  <= HIGH;
                  end else if (stuck_hit) begin
                     stuck_err <= 1'b1;
                     hi_cnt    <= ONE;
                  end else begin
                     hi_cnt <= hi_cnt + ONE;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     lo_cnt <= ONE;
                     state  <= LOW;
                  end else if (stuck_hit) begin
                     stuck_err <= 1'b1;
                     hi_cnt    <= ONE;
                     state     <= SYNC;
                  end else begin
                     hi_cnt <= hi_cnt + ONE;
                  end
               end
               LOW: begin
                  if (rise) begin
                     meas_high   <= hi_cnt;
                     meas_period <= period_sum;
                     meas_valid  <= 1'b1;
                     ratio_err   <= ratio_bad;
                     hi_cnt      <= ONE;
                     state       <= HIGH;
                  end else if (stuck_hit) begin
                     stuck_err <= 1'b1;
                     hi_cnt    <= ONE;
                     state     <= SYNC;
                  end else begin
                     lo_cnt <= lo_cnt + ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // saturating error counter, cleared while the monitor is disabled
   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         err_count <= '0;
      end else if (!enable) begin
         err_count <= '0;
      end else if (err_hit && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: directed and random clk_in patterns checked
// against an edge-timestamp model of the ratio monitor.
module tb_clk_ratio_monitor;

   localparam int DW = 4;
   localparam int CW = 8;

   logic          ref_clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          clk_in = 1'b0;
   logic [DW-1:0] expected_ratio = '0;
   logic [CW-1:0] meas_period;
   logic [CW-1:0] meas_high;
   logic          meas_valid;
   logic          ratio_err;
   logic          stuck_err;
   logic [7:0]    err_count;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   int n_valid = 0;
   int n_rerr = 0;
   int n_serr = 0;

   // model state: sampled levels and edge timestamps
   bit   p1, p2, p3;
   int   now = 0;
   bit   idle = 1'b1;
   bit   armed = 1'b0;
   int   ref_t = 0;
   int   t_rise = 0;
   int   t_fall = -1;
   logic [7:0] exp_period = '0;
   logic [7:0] exp_high = '0;
   bit   exp_valid = 1'b0;
   bit   exp_rerr = 1'b0;
   bit   exp_serr = 1'b0;
   int   exp_cnt = 0;

   clk_ratio_monitor #(
      .DIV_RATIO_WIDTH(DW),
      .CNT_WIDTH(CW)
   ) dut (
      .ref_clk(ref_clk),
      .reset(reset),
      .enable(enable),
      .clk_in(clk_in),
      .expected_ratio(expected_ratio),
      .meas_period(meas_period),
      .meas_high(meas_high),
      .meas_valid(meas_valid),
      .ratio_err(ratio_err),
      .stuck_err(stuck_err),
      .err_count(err_count)
   );

   always #10 ref_clk = ~ref_clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference: a period is measured from rise to rise once a rise has
   // been seen after (re)arming; 127 cycles without the awaited edge is
   // a stuck event that disarms and restarts the timer.
   always @(posedge ref_clk or negedge reset) begin : model
      bit r, f;
      int h, l;
      if (!reset) begin
         p1 = 0; p2 = 0; p3 = 0;
         idle = 1; armed = 0; t_fall = -1;
         exp_period = 0; exp_high = 0;
         exp_valid = 0; exp_rerr = 0; exp_serr = 0;
         exp_cnt = 0;
      end else begin
         r = p2 & ~p3;
         f = ~p2 & p3;
         p3 = p2; p2 = p1; p1 = clk_in;
         now++;
         exp_valid = 0; exp_rerr = 0; exp_serr = 0;
         if (!enable || expected_ratio < 2) begin
            idle = 1;
            armed = 0;
         end else if (idle) begin
            idle = 0;
            armed = 0;
            ref_t = now;
         end else if (!armed) begin
            if (r) begin
               armed = 1;
               t_rise = now;
               t_fall = -1;
               ref_t = now;
            end else if (now - ref_t == 127) begin
               exp_serr = 1;
               ref_t = now;
            end
         end else begin
            if (f && t_fall < 0) begin
               t_fall = now;
               ref_t = now;
            end else if (r && t_fall >= 0) begin
               h = t_fall - t_rise;
               l = now - t_fall;
               exp_high = 8'(h);
               exp_period = 8'(h + l);
               exp_valid = 1;
               exp_rerr = ((h + l) != int'(expected_ratio)) ||
                          (h - l > 1) || (l - h > 1);
               t_rise = now;
               t_fall = -1;
               ref_t = now;
            end else if (now - ref_t == 127) begin
               exp_serr = 1;
               armed = 0;
               ref_t = now;
            end
         end
         if (!enable) exp_cnt = 0;
         else if ((exp_rerr || exp_serr) && exp_cnt < 255) exp_cnt++;
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge ref_clk) begin
      if (chk_on) begin
         check("meas_period", 32'(meas_period), 32'(exp_period));
         check("meas_high", 32'(meas_high), 32'(exp_high));
         check("meas_valid", 32'(meas_valid), 32'(exp_valid));
         check("ratio_err", 32'(ratio_err), 32'(exp_rerr));
         check("stuck_err", 32'(stuck_err), 32'(exp_serr));
         check("err_count", 32'(err_count), 32'(exp_cnt));
      end
   end

   // pulse tallies, sampled after the outputs settle
   always @(posedge ref_clk) begin
      #1;
      if (meas_valid) n_valid++;
      if (ratio_err) n_rerr++;
      if (stuck_err) n_serr++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge ref_clk);
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      repeat (n) begin
         clk_in = 1'b1;
         cyc(hi);
         clk_in = 1'b0;
         cyc(lo);
      end
   endtask

   task automatic start(input int r);
      enable = 1'b0;
      clk_in = 1'b0;
      cyc(10);
      check("disabled_err_count", 32'(err_count), 32'd0);
      expected_ratio = DW'(r);
      enable = 1'b1;
   endtask

   int v0, r0, s0;

   initial begin
      #1 reset = 1'b0;
      chk_on = 1'b1;
      cyc(3);
      check("rst_period", 32'(meas_period), 32'd0);
      check("rst_valid", 32'(meas_valid), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      #1 reset = 1'b1;

      // ratio 4, 50% duty
      start(4);
      v0 = n_valid;
      wave(2, 2, 8);
      check("r4_valid_count", 32'(n_valid - v0), 32'd7);
      check("r4_period", 32'(meas_period), 32'd4);
      check("r4_high", 32'(meas_high), 32'd2);
      check("r4_err_count", 32'(err_count), 32'd0);

      // ratio 5, both odd splits
      start(5);
      wave(2, 3, 6);
      check("r5a_period", 32'(meas_period), 32'd5);
      check("r5a_high", 32'(meas_high), 32'd2);
      wave(3, 2, 6);
      check("r5b_period", 32'(meas_period), 32'd5);
      check("r5b_high", 32'(meas_high), 32'd3);
      check("r5_err_count", 32'(err_count), 32'd0);

      // period mismatch
      start(4);
      r0 = n_rerr;
      wave(3, 3, 6);
      check("mis_period", 32'(meas_period), 32'd6);
      check("mis_rerr_count", 32'(n_rerr - r0), 32'd5);
      check("mis_err_count", 32'(err_count), 32'd5);

      // duty violation with matching period
      start(6);
      wave(1, 5, 5);
      check("duty_period", 32'(meas_period), 32'd6);
      check("duty_high", 32'(meas_high), 32'd1);
      check("duty_err_count", 32'(err_count), 32'd4);

      // stuck high, then recovery
      start(4);
      s0 = n_serr;
      clk_in = 1'b1;
      cyc(300);
      check("stuck_pulses", 32'(n_serr - s0), 32'd2);
      check("stuck_hold_period", 32'(meas_period), 32'd6);
      check("stuck_hold_high", 32'(meas_high), 32'd1);
      check("stuck_err_count", 32'(err_count), 32'd2);
      clk_in = 1'b0;
      cyc(2);
      v0 = n_valid;
      wave(2, 2, 6);
      check("recover_valid", 32'(n_valid - v0), 32'd5);
      check("recover_period", 32'(meas_period), 32'd4);
      check("recover_stuck", 32'(n_serr - s0), 32'd2);

      // asynchronous reset in the middle of a high phase
      start(4);
      clk_in = 1'b1;
      cyc(5);
      @(posedge ref_clk);
      #3 reset = 1'b0;
      #1;
      check("arst_period", 32'(meas_period), 32'd0);
      check("arst_high", 32'(meas_high), 32'd0);
      check("arst_err_count", 32'(err_count), 32'd0);
      #14;
      clk_in = 1'b0;
      reset = 1'b1;
      @(negedge ref_clk);
      v0 = n_valid;
      wave(2, 2, 5);
      check("arst_valid", 32'(n_valid - v0), 32'd4);

      // bypass ratio keeps the monitor idle
      start(1);
      v0 = n_valid; r0 = n_rerr; s0 = n_serr;
      wave(2, 2, 25);
      check("r1_valid", 32'(n_valid - v0), 32'd0);
      check("r1_rerr", 32'(n_rerr - r0), 32'd0);
      check("r1_serr", 32'(n_serr - s0), 32'd0);

      // widest measurable phase, then one cycle longer
      start(4);
      s0 = n_serr;
      wave(127, 5, 2);
      check("w127_high", 32'(meas_high), 32'd127);
      check("w127_period", 32'(meas_period), 32'd132);
      check("w127_stuck", 32'(n_serr - s0), 32'd0);
      start(4);
      s0 = n_serr;
      clk_in = 1'b1;
      cyc(128);
      clk_in = 1'b0;
      cyc(5);
      check("w128_stuck", 32'(n_serr - s0), 32'd1);

      // error counter saturation
      start(4);
      wave(1, 2, 300);
      check("sat_err_count", 32'(err_count), 32'd255);

      // random patterns, ratios and enable toggles
      start(4);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) enable = ~enable;
         if ($urandom_range(0, 3) == 0)
            expected_ratio = DW'($urandom_range(0, 15));
         wave($urandom_range(1, 7), $urandom_range(1, 7),
              $urandom_range(1, 4));
      end
      cyc(5);

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
